// File: rtl/arb_pkg.sv
// Shared types and default configuration for the round-robin beat arbiter.
package arb_pkg;

  typedef struct packed {
    logic urgent;
    logic lock;
  } req_flags_t;

  typedef struct packed {
    req_flags_t flags;
    logic [2:0] tag;
  } req_beat_t;

  typedef struct packed {
    logic       urgent_en;
    logic [3:0] max_burst;
  } arb_cfg_t;

  localparam arb_cfg_t DEFAULT_CFG = '{urgent_en: 1'b1, max_burst: 4'd4};

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Round-robin picker: first set mask bit after ptr, wrapping modulo NREQ.
// Latency: purely combinational.
// Backpressure: none; caller qualifies sel_vld with its own load enable.
module arb_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         mask,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] sel,
  output logic                    sel_vld
);

  localparam int IW = $clog2(NREQ);

  // Walk from farthest to nearest so the nearest hit after ptr wins.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (mask[(int'(ptr) + k) % NREQ]) begin
        sel     = IW'((int'(ptr) + k) % NREQ);
        sel_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cfg_rr_arbiter.sv
// Round-robin arbiter with urgent override and locked bursts onto one output register.
// Latency: beat accepted in cycle N is on out_* in cycle N+1; one beat per cycle.
// Backpressure: req_ready is withheld while the output register is full and not being popped.
module cfg_rr_arbiter
  import arb_pkg::*;
#(
  parameter int       NREQ = 4,
  parameter arb_cfg_t CFG  = DEFAULT_CFG
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  req_beat_t [NREQ-1:0]    req_beat,
  output logic [NREQ-1:0]         req_ready,
  output logic                    out_valid,
  output req_beat_t               out_beat,
  output logic [$clog2(NREQ)-1:0] out_src,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int         IW      = $clog2(NREQ);
  localparam logic [3:0] EFF_MAX = (CFG.max_burst == 4'd0) ? 4'd1 : CFG.max_burst;
  localparam bit         LOCK_OK = (EFF_MAX > 4'd1);

  arb_state_t      state, state_nxt;
  logic [IW-1:0]   rr_ptr, owner, sel;
  logic [3:0]      burst_cnt, cnt_inc;
  logic [NREQ-1:0] urg_mask, own_oh, mask;
  logic            sel_vld, ld, xfer;
  req_beat_t       sel_beat;

  always_comb begin
    urg_mask = '0;
    own_oh   = '0;
    for (int i = 0; i < NREQ; i++) begin
      urg_mask[i] = req_valid[i] && req_beat[i].flags.urgent;
    end
    own_oh[owner] = 1'b1;
  end

  // A lock owner excludes everyone, urgent requesters included.
  always_comb begin
    mask = req_valid;
    if (state == LOCKED) begin
      mask = req_valid & own_oh;
    end else if (CFG.urgent_en && (|urg_mask)) begin
      mask = urg_mask;
    end
  end

  arb_rr_pick #(.NREQ(NREQ)) u_pick (
    .mask    (mask),
    .ptr     (rr_ptr),
    .sel     (sel),
    .sel_vld (sel_vld)
  );

  assign ld       = !out_valid || out_ready;
  assign xfer     = ld && sel_vld;
  assign sel_beat = req_beat[sel];
  assign cnt_inc  = (burst_cnt == 4'hF) ? 4'hF : burst_cnt + 4'd1;
  assign busy     = (state == LOCKED) || out_valid;

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[sel] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer && sel_beat.flags.lock && LOCK_OK) state_nxt = LOCKED;
      LOCKED:  if (xfer && (!sel_beat.flags.lock || cnt_inc == EFF_MAX)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
      out_src   <= '0;
      rr_ptr    <= IW'(NREQ - 1);
      owner     <= '0;
      burst_cnt <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_beat  <= sel_beat;
      out_src   <= sel;
      rr_ptr    <= sel;
      if (state == IDLE) begin
        if (state_nxt == LOCKED) begin
          owner     <= sel;
          burst_cnt <= 4'd1;
        end
      end else begin
        burst_cnt <= cnt_inc;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
